// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encodings, load opcodes and bus layouts for the MEM stage.
package mem_stage_pkg;

  localparam int STALL_W      = 6;
  localparam int EX_TO_MEM_WD = 141;
  localparam int MEM_TO_WB_WD = 136;
  localparam int MEM_TO_ID_WD = 38;

  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LBU  = 3'b010;
  localparam logic [2:0] LD_LH   = 3'b011;
  localparam logic [2:0] LD_LHU  = 3'b100;
  localparam logic [2:0] LD_LW   = 3'b101;

  // Read-data source for a resident load.
  typedef enum logic {
    LIVE = 1'b0,
    HELD = 1'b1
  } hold_state_e;

  // Field view of the EX-to-MEM bus; any bits above this are spare.
  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  ld_op;
    logic        data_ram_en;
    logic        hi_we;
    logic        lo_we;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [31:0] hi;
    logic [31:0] lo;
  } ex_mem_t;

  localparam int EX_FIELDS_WD = $bits(ex_mem_t);

  typedef struct packed {
    logic [31:0] pc;
    logic        hi_we;
    logic        lo_we;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] hi;
    logic [31:0] lo;
  } mem_wb_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_id_t;

  function automatic logic is_load(input logic [2:0] ld_op, input logic data_ram_en);
    return data_ram_en && (ld_op != LD_NONE);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane select and sign/zero extension; purely combinational.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  ld_op,
  input  logic [31:0] rdata,
  output logic [31:0] data_o
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Misaligned halfword/word addresses only pick a lane; low bits are ignored.
  assign w_shifted = rdata >> {addr, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = addr[1] ? rdata[31:16] : rdata[15:0];

  // Extend the selected lane according to the load type.
  always_comb begin
    data_o = rdata;
    case (ld_op)
      LD_LB:   data_o = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  data_o = {24'h000000, w_byte};
      LD_LH:   data_o = {{16{w_half[15]}}, w_half};
      LD_LHU:  data_o = {16'h0000, w_half};
      LD_LW:   data_o = rdata;
      default: data_o = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, load read-data hold path, WB and ID buses.
//
// state | meaning
// LIVE  | load data comes straight from data_sram_rdata
// HELD  | WB is stalled with a load resident; data comes from r_rdata_hold
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int STALL_W      = mem_stage_pkg::STALL_W,
  parameter int EX_TO_MEM_WD = mem_stage_pkg::EX_TO_MEM_WD,
  parameter int MEM_TO_WB_WD = mem_stage_pkg::MEM_TO_WB_WD
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_fwd
);

  ex_mem_t     r_mem;
  logic [31:0] r_rdata_hold;
  hold_state_e r_state;

  ex_mem_t     w_ex;
  logic        w_mem_stop;
  logic        w_wb_stop;
  logic        w_mem_change;
  logic        w_load_res;
  logic [31:0] w_rdata;
  logic [31:0] w_ld_data;
  logic [31:0] w_rf_wdata;
  mem_wb_t     w_wb;
  mem_id_t     w_id;
  logic        w_unused_bits;

  assign w_ex         = ex_mem_t'(ex_to_mem_bus[EX_FIELDS_WD-1:0]);
  assign w_mem_stop   = (stall[STALL_MEM] == STOP);
  assign w_wb_stop    = (stall[STALL_WB] == STOP);
  // The MEM register takes either a new instruction or a bubble unless both stages stop.
  assign w_mem_change = !w_mem_stop || !w_wb_stop;
  assign w_load_res   = is_load(r_mem.ld_op, r_mem.data_ram_en);

  // Spare bus bits and unused stall lanes are deliberately ignored.
  assign w_unused_bits = ^{ex_to_mem_bus, stall};

  // EX/MEM register: capture, insert a bubble, or hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem <= '0;
    end else if (!w_mem_stop) begin
      r_mem <= w_ex;
    end else if (!w_wb_stop) begin
      r_mem <= '0;
    end
  end

  // Hold FSM: freeze the SRAM word the first cycle a resident load sees WB stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= LIVE;
      r_rdata_hold <= '0;
    end else if (w_mem_change) begin
      // A bubble or new instruction always starts LIVE; the bubble wins over HELD.
      r_state <= LIVE;
    end else begin
      case (r_state)
        LIVE: begin
          if (w_load_res) begin
            r_state      <= HELD;
            r_rdata_hold <= data_sram_rdata;
          end
        end
        HELD:    r_state <= HELD;
        default: r_state <= LIVE;
      endcase
    end
  end

  assign w_rdata = (r_state == HELD) ? r_rdata_hold : data_sram_rdata;

  load_align u_load_align (
    .addr   (r_mem.ex_result[1:0]),
    .ld_op  (r_mem.ld_op),
    .rdata  (w_rdata),
    .data_o (w_ld_data)
  );

  assign w_rf_wdata = w_load_res ? w_ld_data : r_mem.ex_result;

  // Output buses are combinational views of the register; a bubble reads as all-zero.
  always_comb begin
    w_wb          = '0;
    w_wb.pc       = r_mem.pc;
    w_wb.hi_we    = r_mem.hi_we;
    w_wb.lo_we    = r_mem.lo_we;
    w_wb.rf_we    = r_mem.rf_we;
    w_wb.rf_waddr = r_mem.rf_waddr;
    w_wb.rf_wdata = w_rf_wdata;
    w_wb.hi       = r_mem.hi;
    w_wb.lo       = r_mem.lo;

    w_id          = '0;
    w_id.rf_we    = r_mem.rf_we;
    w_id.rf_waddr = r_mem.rf_waddr;
    w_id.rf_wdata = w_rf_wdata;
  end

  assign mem_to_wb_bus = MEM_TO_WB_WD'(w_wb);
  assign mem_to_id_fwd = w_id;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected WB words are queued as EX stimulus is driven.
module tb_mem_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  ld_op;
    logic        en;
    logic        hi_we;
    logic        lo_we;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] word;
  } ins_t;

  logic         clk;
  logic         resetn;
  logic [5:0]   stall;
  logic [140:0] ex_to_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic [135:0] mem_to_wb_bus;
  logic [37:0]  mem_to_id_fwd;

  int n_chk  = 0;
  int n_pass = 0;

  logic [135:0] q[$];
  logic [135:0] last_wb;
  logic [37:0]  last_fwd;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_fwd   (mem_to_id_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] ext(input logic [2:0] op, input logic [1:0] a, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {24'd0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [135:0] exp_wb(input ins_t i);
    logic [31:0] wd;
    wd = (i.ld_op != 3'd0 && i.en) ? ext(i.ld_op, i.res[1:0], i.word) : i.res;
    return {i.pc, i.hi_we, i.lo_we, i.rf_we, i.waddr, wd, i.hi, i.lo};
  endfunction

  function automatic logic [140:0] pack(input ins_t i);
    return {1'b0, i.pc, i.ld_op, i.en, i.hi_we, i.lo_we, i.rf_we, i.waddr, i.res, i.hi, i.lo};
  endfunction

  function automatic ins_t mk(input logic [31:0] pc, input logic [2:0] op, input logic en,
                              input logic [4:0] wa, input logic [31:0] res, input logic [31:0] word);
    ins_t i;
    i.pc = pc; i.ld_op = op; i.en = en;
    i.hi_we = pc[2]; i.lo_we = pc[3]; i.rf_we = 1'b1;
    i.waddr = wa; i.res = res;
    i.hi = ~pc; i.lo = pc ^ 32'h5A5A_A5A5; i.word = word;
    return i;
  endfunction

  function automatic ins_t rnd();
    ins_t i;
    i.pc = $urandom; i.ld_op = 3'($urandom_range(0, 5)); i.en = 1'($urandom);
    i.hi_we = 1'($urandom); i.lo_we = 1'($urandom); i.rf_we = 1'($urandom);
    i.waddr = 5'($urandom); i.res = $urandom; i.hi = $urandom; i.lo = $urandom;
    i.word = $urandom;
    return i;
  endfunction

  // One cycle: drive EX/stall/rdata, check the resident entry, then advance the scoreboard.
  task automatic drive(input ins_t ex, input logic [5:0] st, input logic [31:0] rd);
    logic [135:0] e;
    ex_to_mem_bus   = pack(ex);
    stall           = st;
    data_sram_rdata = rd;
    @(negedge clk);
    last_wb  = mem_to_wb_bus;
    last_fwd = mem_to_id_fwd;
    if (q.size() == 0) begin
      chk("sb_empty", 136'(q.size()), 136'd1);
    end else begin
      e = q[0];
      chk("wb_bus", mem_to_wb_bus, e);
      chk("id_fwd", 136'(mem_to_id_fwd), 136'(e[101:64]));
    end
    if (!st[3]) q.push_back(exp_wb(ex));
    else if (!st[4]) q.push_back('0);
    @(posedge clk);
    #1;
    if ((!st[3] || !st[4]) && q.size() > 0) void'(q.pop_front());
  endtask

  initial begin
    ins_t i_lb, i_lbu, i_lh, i_lhu, i_lw, i_n, i_b, i_r, i_p, i_x, i_m;
    logic [31:0] prev_word;

    resetn = 1'b0;
    stall = '0;
    ex_to_mem_bus = '0;
    data_sram_rdata = '0;
    q.push_back('0);
    #12;
    chk("rst_wb", mem_to_wb_bus, '0);
    chk("rst_fwd", 136'(mem_to_id_fwd), '0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // byte and halfword extension
    i_lb  = mk(32'h0000_1000, 3'd1, 1'b1, 5'd1, 32'h1000_0003, 32'h80FF_1234);
    i_lbu = mk(32'h0000_1004, 3'd2, 1'b1, 5'd2, 32'h1000_0003, 32'h80FF_1234);
    i_lh  = mk(32'h0000_1008, 3'd3, 1'b1, 5'd3, 32'h1000_0002, 32'h8001_7FFF);
    i_lhu = mk(32'h0000_100C, 3'd4, 1'b1, 5'd4, 32'h1000_0000, 32'h8001_7FFF);
    i_n   = mk(32'h0000_1010, 3'd0, 1'b0, 5'd5, 32'h0000_0042, 32'h0);
    drive(i_lb, 6'b0, 32'h0);
    drive(i_lbu, 6'b0, 32'h80FF_1234);
    chk("lb_sext", 136'(last_fwd[31:0]), 136'(32'hFFFF_FF80));
    drive(i_lh, 6'b0, 32'h80FF_1234);
    chk("lbu_zext", 136'(last_fwd[31:0]), 136'(32'h0000_0080));
    drive(i_lhu, 6'b0, 32'h8001_7FFF);
    chk("lh_sext", 136'(last_fwd[31:0]), 136'(32'hFFFF_8001));
    drive(i_n, 6'b0, 32'h8001_7FFF);
    chk("lhu_zext", 136'(last_fwd[31:0]), 136'(32'h0000_7FFF));

    // hold path: lw resident while WB stalls, SRAM word changes underneath
    i_lw = mk(32'h0000_2000, 3'd5, 1'b1, 5'd6, 32'h2000_0001, 32'h1122_3344);
    drive(i_lw, 6'b0, 32'h0);
    drive(i_n, 6'b011000, 32'h1122_3344);
    drive(i_n, 6'b011000, 32'hDEAD_BEEF);
    drive(i_n, 6'b011000, 32'hDEAD_BEEF);
    drive(i_n, 6'b000000, 32'hDEAD_BEEF);
    chk("hold_word", 136'(last_wb[95:64]), 136'(32'h1122_3344));

    // bubble insertion, EX instruction consumed afterwards
    i_b = mk(32'h0000_3000, 3'd0, 1'b0, 5'd7, 32'h0BAD_F00D, 32'h0);
    drive(i_b, 6'b001000, 32'h0);
    drive(i_b, 6'b000000, 32'h0);
    chk("bubble", last_wb, '0);
    drive(i_n, 6'b000000, 32'h0);
    chk("bubble_later", 136'(last_wb[135:104]), 136'(32'h0000_3000));

    // hold of a non-load result
    i_r = mk(32'h0000_4000, 3'd0, 1'b1, 5'd8, 32'h1234_5678, 32'h0);
    drive(i_r, 6'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(i_n, 6'b011000, 32'hFFFF_FFFF);
      chk("hold_fwd", 136'(last_fwd[31:0]), 136'(32'h1234_5678));
    end
    drive(i_n, 6'b0, 32'h0);
    chk("hold_fwd_rel", 136'(last_fwd[31:0]), 136'(32'h1234_5678));

    // load arriving with a bubble stall: bubble wins, next load reads live data
    i_p = mk(32'h0000_5000, 3'd2, 1'b1, 5'd9, 32'h5000_0001, 32'hAABB_CCDD);
    i_x = mk(32'h0000_5004, 3'd5, 1'b1, 5'd10, 32'h5000_0004, 32'h0F0F_0F0F);
    drive(i_p, 6'b0, 32'h0);
    drive(i_x, 6'b001000, 32'hAABB_CCDD);
    drive(i_x, 6'b0, 32'h5555_5555);
    drive(i_n, 6'b0, 32'h0F0F_0F0F);

    // random stream with mixed stalls
    prev_word = 32'h0;
    for (int k = 0; k < 24; k++) begin
      ins_t ri;
      logic [5:0] st;
      ri = rnd();
      case ($urandom_range(0, 5))
        0:       st = 6'b001000;
        1:       st = 6'b011000;
        default: st = 6'b000000;
      endcase
      drive(ri, st, prev_word);
      if (st == 6'b0) prev_word = ri.word;
      else if (st == 6'b001000) prev_word = $urandom;
    end
    drive(i_n, 6'b0, prev_word);

    // mid-stream reset while a load is held
    i_m = mk(32'h0000_6000, 3'd5, 1'b1, 5'd11, 32'h6000_0000, 32'h1212_1212);
    drive(i_m, 6'b0, 32'h0);
    drive(i_n, 6'b011000, 32'h1212_1212);
    resetn = 1'b0;
    #1;
    chk("midrst_wb", mem_to_wb_bus, '0);
    chk("midrst_fwd", 136'(mem_to_id_fwd), '0);
    q.delete();
    q.push_back('0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    i_x = mk(32'h0000_7000, 3'd5, 1'b1, 5'd12, 32'h7000_0000, 32'h3434_3434);
    drive(i_x, 6'b0, 32'hDEAD_BEEF);
    chk("post_rst_zero", last_wb, '0);
    drive(i_n, 6'b0, 32'h3434_3434);
    chk("post_rst_ld", 136'(last_fwd[31:0]), 136'(32'h3434_3434));
    drive(i_n, 6'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
